// File: rtl/bit_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package bit_serial_adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Bit-counter width; indexes bits 0..width-1 and never needs to hold width itself.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// Combinational 1-bit full adder used as the single arithmetic cell of the serial datapath.
module serial_fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic c
);

   assign s = a ^ b ^ cin;
   assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder/subtractor: one full-adder cell, registered carry, one bit per clock.
// Optional serial result port enabled by defining BIT_SERIAL_ADDER_SOUT_EN.
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
`ifdef BIT_SERIAL_ADDER_SOUT_EN
   ,
   output logic             sout,
   output logic             sout_valid
`endif
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-2:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
`ifdef BIT_SERIAL_ADDER_SOUT_EN
   logic             sout_q, sout_d;
   logic             sout_valid_q, sout_valid_d;
`endif

   logic fa_s;
   logic fa_c;

   serial_fa_cell u_fa (
      .a   (a_q[0]),
      .b   (b_q[0]),
      .cin (carry_q),
      .s   (fa_s),
      .c   (fa_c)
   );

   // The low WIDTH-1 result bits accumulate in res_q; the final bit joins them at the done edge.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
`ifdef BIT_SERIAL_ADDER_SOUT_EN
      sout_d       = sout_q;
      sout_valid_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = '0;
               state_d = RUN;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            res_d   = (WIDTH-1)'({fa_s, res_q} >> 1);
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            carry_d = fa_c;
            cnt_d   = cnt_q + 1'b1;
`ifdef BIT_SERIAL_ADDER_SOUT_EN
            sout_d       = fa_s;
            sout_valid_d = 1'b1;
`endif
            if (cnt_q == LAST_BIT) begin
               sum_d   = {fa_s, res_q};
               cout_d  = fa_c;
               ovf_d   = fa_c ^ carry_q;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef BIT_SERIAL_ADDER_SOUT_EN
         sout_q       <= 1'b0;
         sout_valid_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
`ifdef BIT_SERIAL_ADDER_SOUT_EN
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
`ifdef BIT_SERIAL_ADDER_SOUT_EN
   assign sout       = sout_q;
   assign sout_valid = sout_valid_q;
`endif

endmodule
